// File: rtl/collatz_engine.sv
// Collatz step counter kernel: start/busy/finish handshake, 2-stage loop body at II=2, step-limit and
// 3n+1 overflow detection. Define COLLATZ_PEAK_EN to add the ret_peak output (peak value tracking).
module collatz_engine #(
  parameter int WIDTH     = 32,
  parameter int STEP_W    = 16,
  parameter int MAX_STEPS = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WIDTH-1:0]  n,
  output logic              busy,
  output logic              finish,
  output logic [STEP_W-1:0] ret_steps,
  output logic [1:0]        ret_err
`ifdef COLLATZ_PEAK_EN
  ,
  output logic [WIDTH-1:0]  ret_peak
`endif
);

  typedef enum logic [2:0] {IDLE, INIT, LOOP, EXIT, DONE} state_t;

  localparam logic [STEP_W-1:0] MAX_C = STEP_W'(MAX_STEPS);
  localparam logic [WIDTH-1:0]  ONE   = WIDTH'(1);
  localparam logic [WIDTH+1:0]  ONE_X = (WIDTH+2)'(1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   n_q, n_d;
  logic [WIDTH-1:0]   cur_q, cur_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic               s0_en_q, s0_en_d;
  logic               s1_en_q, s1_en_d;
  logic               flush_q, flush_d;
  logic [1:0]         err_q, err_d;
  logic [WIDTH-1:0]   half_q, half_d;
  logic [WIDTH-1:0]   triple_lo_q, triple_lo_d;
  logic               odd_q, odd_d;
  logic [STEP_W-1:0]  step_inc_q, step_inc_d;
  logic [STEP_W-1:0]  ret_steps_q, ret_steps_d;
  logic [1:0]         ret_err_q, ret_err_d;

  logic [WIDTH+1:0]   triple_c;
  logic [WIDTH-1:0]   cur_new_c;
  logic               test_c, cont_c, ovf_c;

  assign triple_c  = ({2'b00, cur_q} << 1) + {2'b00, cur_q} + ONE_X;
  assign ovf_c     = cur_q[0] && (triple_c[WIDTH+1:WIDTH] != 2'b00);
  assign test_c    = (cur_q > ONE) && (step_q < MAX_C);
  assign cur_new_c = odd_q ? triple_lo_q : half_q;
  // Stage1 also evaluates the next while-test so a normal exit retires without a bubble cycle.
  assign cont_c    = (cur_new_c > ONE) && (step_inc_q < MAX_C);

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    cur_d       = cur_q;
    step_d      = step_q;
    s0_en_d     = s0_en_q;
    s1_en_d     = s1_en_q;
    flush_d     = flush_q;
    err_d       = err_q;
    half_d      = half_q;
    triple_lo_d = triple_lo_q;
    odd_d       = odd_q;
    step_inc_d  = step_inc_q;
    ret_steps_d = ret_steps_q;
    ret_err_d   = ret_err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          n_d     = n;
          state_d = INIT;
        end
      end
      INIT: begin
        cur_d   = n_q;
        step_d  = '0;
        flush_d = 1'b0;
        err_d   = 2'b00;
        s1_en_d = 1'b0;
        s0_en_d = (n_q > ONE);
        state_d = (n_q > ONE) ? LOOP : EXIT;
      end
      LOOP: begin
        if (s0_en_q) begin
          s0_en_d = 1'b0;
          if (!test_c) begin
            flush_d  = 1'b1;
            err_d[1] = (cur_q > ONE);
          end else if (ovf_c) begin
            // Squash this iteration: cur and step keep their pre-iteration values.
            flush_d  = 1'b1;
            err_d[0] = 1'b1;
          end else begin
            half_d      = cur_q >> 1;
            triple_lo_d = triple_c[WIDTH-1:0];
            odd_d       = cur_q[0];
            step_inc_d  = step_q + STEP_W'(1);
            s1_en_d     = 1'b1;
          end
        end
        if (s1_en_q) begin
          s1_en_d = 1'b0;
          cur_d   = cur_new_c;
          step_d  = step_inc_q;
          if (cont_c) begin
            s0_en_d = 1'b1;
          end else begin
            flush_d  = 1'b1;
            err_d[1] = (cur_new_c > ONE);
            state_d  = EXIT;
          end
        end
        if (flush_q && !s0_en_q && !s1_en_q) begin
          state_d = EXIT;
        end
      end
      EXIT: begin
        ret_steps_d = step_q;
        ret_err_d   = err_q;
        state_d     = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      n_q         <= '0;
      cur_q       <= '0;
      step_q      <= '0;
      s0_en_q     <= 1'b0;
      s1_en_q     <= 1'b0;
      flush_q     <= 1'b0;
      err_q       <= 2'b00;
      half_q      <= '0;
      triple_lo_q <= '0;
      odd_q       <= 1'b0;
      step_inc_q  <= '0;
      ret_steps_q <= '0;
      ret_err_q   <= 2'b00;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      cur_q       <= cur_d;
      step_q      <= step_d;
      s0_en_q     <= s0_en_d;
      s1_en_q     <= s1_en_d;
      flush_q     <= flush_d;
      err_q       <= err_d;
      half_q      <= half_d;
      triple_lo_q <= triple_lo_d;
      odd_q       <= odd_d;
      step_inc_q  <= step_inc_d;
      ret_steps_q <= ret_steps_d;
      ret_err_q   <= ret_err_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign finish    = (state_q == DONE);
  assign ret_steps = ret_steps_q;
  assign ret_err   = ret_err_q;

`ifdef COLLATZ_PEAK_EN
  logic [WIDTH-1:0] peak_q, peak_d;
  logic [WIDTH-1:0] ret_peak_q, ret_peak_d;

  always_comb begin
    peak_d     = peak_q;
    ret_peak_d = ret_peak_q;
    if (state_q == INIT) begin
      peak_d = n_q;
    end else if ((state_q == LOOP) && s1_en_q && (cur_new_c > peak_q)) begin
      peak_d = cur_new_c;
    end
    if (state_q == EXIT) begin
      ret_peak_d = peak_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      peak_q     <= '0;
      ret_peak_q <= '0;
    end else begin
      peak_q     <= peak_d;
      ret_peak_q <= ret_peak_d;
    end
  end

  assign ret_peak = ret_peak_q;
`endif

endmodule

// File: tb/tb_collatz_engine.sv
// Directed bench for collatz_engine: default, WIDTH=8 and MAX_STEPS=10 instances share clock and reset;
// sel routes start to one instance and muxes its outputs for checking.
module tb_collatz_engine;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] n_drv;
  int          sel;
  int          total;
  int          bad;

  logic        start0, start1, start2;
  logic        busy0, busy1, busy2;
  logic        fin0, fin1, fin2;
  logic [15:0] steps0, steps1, steps2;
  logic [1:0]  err0, err1, err2;

  logic        busy_o, fin_o;
  logic [15:0] steps_o;
  logic [1:0]  err_o;

`ifdef COLLATZ_PEAK_EN
  logic [31:0] peak0, peak2, peak_o;
  logic [7:0]  peak1;
`endif

  assign start0 = start && (sel == 0);
  assign start1 = start && (sel == 1);
  assign start2 = start && (sel == 2);

  collatz_engine u_dut (
    .clk(clk), .rst_n(rst_n), .start(start0), .n(n_drv),
    .busy(busy0), .finish(fin0), .ret_steps(steps0), .ret_err(err0)
`ifdef COLLATZ_PEAK_EN
    , .ret_peak(peak0)
`endif
  );

  collatz_engine #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .start(start1), .n(n_drv[7:0]),
    .busy(busy1), .finish(fin1), .ret_steps(steps1), .ret_err(err1)
`ifdef COLLATZ_PEAK_EN
    , .ret_peak(peak1)
`endif
  );

  collatz_engine #(.MAX_STEPS(10)) u_lim (
    .clk(clk), .rst_n(rst_n), .start(start2), .n(n_drv),
    .busy(busy2), .finish(fin2), .ret_steps(steps2), .ret_err(err2)
`ifdef COLLATZ_PEAK_EN
    , .ret_peak(peak2)
`endif
  );

  always_comb begin
    busy_o  = busy0;
    fin_o   = fin0;
    steps_o = steps0;
    err_o   = err0;
    if (sel == 1) begin
      busy_o  = busy1;
      fin_o   = fin1;
      steps_o = steps1;
      err_o   = err1;
    end else if (sel == 2) begin
      busy_o  = busy2;
      fin_o   = fin2;
      steps_o = steps2;
      err_o   = err2;
    end
  end

`ifdef COLLATZ_PEAK_EN
  always_comb begin
    peak_o = peak0;
    if (sel == 1) peak_o = {24'd0, peak1};
    else if (sel == 2) peak_o = peak2;
  end
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Latency counts the cycle right after the accept edge as 1; returns 5000 if finish never arrives.
  task automatic applyStimulus(input int sel_i, input logic [31:0] n_i, output int lat);
    @(negedge clk);
    sel   = sel_i;
    n_drv = n_i;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!fin_o && lat < 5000) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic runCheck(input string tag, input int sel_i, input logic [31:0] n_i,
                          input int exp_steps, input int exp_err, input int exp_lat);
    int lat;
    applyStimulus(sel_i, n_i, lat);
    checkOutput({tag, "_lat"}, lat, exp_lat);
    checkOutput({tag, "_steps"}, steps_o, exp_steps);
    checkOutput({tag, "_err"}, err_o, exp_err);
    @(negedge clk);
    checkOutput({tag, "_fin_drop"}, fin_o, 0);
    checkOutput({tag, "_busy_drop"}, busy_o, 0);
    checkOutput({tag, "_held"}, steps_o, exp_steps);
  endtask

  initial begin
    int lat;
    logic fin_seen;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    sel   = 0;
    n_drv = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_finish", fin_o, 0);
    checkOutput("rst_steps", steps_o, 0);
    checkOutput("rst_err", err_o, 0);
    rst_n = 1'b1;

    runCheck("n1", 0, 32'd1, 0, 0, 3);
    runCheck("n0", 0, 32'd0, 0, 0, 3);
    runCheck("n6", 0, 32'd6, 8, 0, 19);
    runCheck("n27", 0, 32'd27, 111, 0, 225);
`ifdef COLLATZ_PEAK_EN
    checkOutput("n27_peak", peak_o, 9232);
`endif

    runCheck("w8_n255", 1, 32'd255, 0, 1, 5);
`ifdef COLLATZ_PEAK_EN
    checkOutput("w8_n255_peak", peak_o, 255);
`endif
    runCheck("w8_n27", 1, 32'd27, 11, 1, 27);
    runCheck("w8_n6", 1, 32'd6, 8, 0, 19);

    runCheck("lim_n27", 2, 32'd27, 10, 2, 23);
    runCheck("lim_n24", 2, 32'd24, 10, 0, 23);
    runCheck("lim_n3", 2, 32'd3, 7, 0, 17);

    // start held high through a whole run, with n changing mid-run
    @(negedge clk);
    sel   = 0;
    n_drv = 32'd6;
    start = 1'b1;
    @(negedge clk);
    n_drv = 32'd100;
    lat   = 1;
    while (!fin_o && lat < 5000) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("flood_lat", lat, 19);
    checkOutput("flood_steps", steps_o, 8);
    n_drv = 32'd7;
    @(negedge clk);
    checkOutput("flood_idle_busy", busy_o, 0);
    checkOutput("flood_idle_steps", steps_o, 8);
    @(negedge clk);
    start = 1'b0;
    checkOutput("flood_reaccept_busy", busy_o, 1);
    lat = 1;
    while (!fin_o && lat < 5000) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("flood_n7_lat", lat, 35);
    checkOutput("flood_n7_steps", steps_o, 16);

    // one-cycle reset in the middle of a long run
    @(negedge clk);
    n_drv = 32'd27;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("midrst_busy_before", busy_o, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midrst_busy", busy_o, 0);
    checkOutput("midrst_finish", fin_o, 0);
    checkOutput("midrst_steps", steps_o, 0);
    checkOutput("midrst_err", err_o, 0);
    fin_seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (fin_o) fin_seen = 1'b1;
    end
    checkOutput("midrst_no_finish", fin_seen, 0);
    runCheck("post_rst_n6", 0, 32'd6, 8, 0, 19);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
